npc_unit: RTL and testbench
===========================

NPC_UNIT -- requirements
Module: npc_unit

Interface
REQ-001 SHALL have parameter CYCLES, default 5, the number of clock periods per instruction (legal range 3..8).
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, the redirect target for a misaligned control transfer.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block's only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pc  input  32  current PC from the PC register.
REQ-006 SHALL have port jmp_type  input  2  control type: 00 sequential, 01 conditional branch, 10 jal, 11 jalr.
REQ-007 SHALL have port br_cond  input  1  branch condition from the ALU; sampled only when jmp_type=01.
REQ-008 SHALL have port imm  input  32  sign-extended immediate.
REQ-009 SHALL have port rs1_val  input  32  register rs1 value, used by jalr.
REQ-010 SHALL have port stall  input  1  freezes the phase counter.
REQ-011 SHALL have port npc  output  32  next PC, driven to the PC register every cycle.
REQ-012 SHALL have port pc4  output  32  pc+4, the link value for jal and jalr.
REQ-013 SHALL have port phase  output  3  current phase, 0..CYCLES-1.
REQ-014 SHALL have port commit  output  1  high during the last phase of each instruction.
REQ-015 SHALL have port misalign  output  1  one-cycle pulse on a misaligned redirect.

Function
REQ-016 SHALL advance phase by 1 on each clk edge with stall=0, wrapping from CYCLES-1 to 0; with stall=1, phase SHALL hold.
REQ-017 SHALL drive commit=1 exactly when phase==CYCLES-1 and stall=0.
REQ-018 SHALL drive npc=pc whenever commit=0, so the PC register holds the PC between instructions.
REQ-019 SHALL capture the redirect at the clk edge ending phase 2 (EX) with stall=0; the captured state is redir_vld and redir_tgt.
REQ-020 SHALL compute the captured target as: 01 with br_cond=1 gives pc+imm; 10 gives pc+imm; 11 gives (rs1_val+imm) with bit0 cleared; redir_vld=0 for 00, and for 01 with br_cond=0.
REQ-021 SHALL use 32-bit wrap-around arithmetic throughout with no overflow detection (32'hFFFF_FFFC+4 gives 0).
REQ-022 SHALL drive npc, when commit=1, to redir_tgt if redir_vld=1, otherwise to pc+4.
REQ-023 SHALL clear redir_vld on the clk edge where commit=1, so no redirect carries into the next instruction.
REQ-024 SHALL, when stall=1 in phase 2, not capture the redirect; capture occurs on the first non-stalled edge in phase 2.
REQ-025 SHALL, when stall=1 in the last phase, keep commit=0 and npc=pc until stall falls.
REQ-026 SHALL drive pc4=pc+4 combinationally, with zero latency.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force phase=0, redir_vld=0, redir_tgt=0 and misalign=0; npc then follows pc and commit=0.
REQ-028 SHALL, when reset is asserted mid-instruction, discard any captured redirect, and after release restart at phase 0.

Configuration
REQ-029 SHALL, with macro NPC_MISALIGN_TRAP_EN defined, drive npc=TRAP_VEC at commit if redir_vld=1 and redir_tgt[1]=1, and pulse misalign for that one cycle.
REQ-030 SHALL, with NPC_MISALIGN_TRAP_EN undefined, tie misalign to 0 and pass redir_tgt to npc unchanged.

Verification
REQ-031 SHALL cover a sequential instruction: pc=0x10, jmp_type=00, CYCLES=5 -> npc=0x10 in phases 0-3, npc=0x14 with commit=1 in phase 4.
REQ-032 SHALL cover branch taken vs not taken: pc=0x40, imm=0xFFFF_FFF0, br_cond=1 -> npc=0x30 at commit; the same stimulus with br_cond=0 -> npc=0x44.
REQ-033 SHALL cover jalr: rs1_val=0x1001, imm=4, pc=0x80 -> npc=0x1004 at commit and pc4=0x84 throughout.
REQ-034 SHALL cover a stall: stall=1 for 3 cycles in phase 2 with jal imm=8 -> phase holds at 2, capture occurs after stall falls, commit arrives 3 cycles later than without stall, npc=pc+8.
REQ-035 SHALL cover reset mid-instruction: rst_n pulsed low in phase 3 after a captured jal -> phase=0, redir_vld=0, and the next commit gives pc+4.
REQ-036 SHALL cover misalign with NPC_MISALIGN_TRAP_EN defined: jal from pc=0 with imm=6 -> npc=0x100 and misalign=1 for one cycle; without the macro -> npc=0x6 and misalign=0.

Source files
------------

// File: rtl/npc_unit.sv
// Next-PC unit for a multi-cycle core: phase sequencer, EX-stage redirect capture, commit-time PC select.
// Optional misaligned-target trap is enabled by defining NPC_MISALIGN_TRAP_EN.
module npc_unit #(
  parameter int unsigned CYCLES   = 5,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [1:0]  jmp_type,
  input  logic        br_cond,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        stall,
  output logic [31:0] npc,
  output logic [31:0] pc4,
  output logic [2:0]  phase,
  output logic        commit,
  output logic        misalign
);

  typedef enum logic [1:0] {
    JMP_SEQ  = 2'b00,
    JMP_BR   = 2'b01,
    JMP_JAL  = 2'b10,
    JMP_JALR = 2'b11
  } jmp_e;

  localparam logic [2:0] LAST_PH = 3'(CYCLES - 1);
  localparam logic [2:0] EX_PH   = 3'd2;
  // With CYCLES=3 the EX phase is also the commit phase, so commit must use the live target.
  localparam bit EX_IS_LAST = (CYCLES == 3);

`ifdef NPC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  jmp_e        jmp;
  logic [2:0]  phase_q, phase_d;
  logic        redir_vld_q, redir_vld_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [31:0] pc_plus4;
  logic        live_vld;
  logic [31:0] live_tgt;
  logic        capture;
  logic        eff_vld;
  logic [31:0] eff_tgt;

  assign jmp      = jmp_e'(jmp_type);
  assign pc_plus4 = pc + 32'd4;
  assign pc4      = pc_plus4;
  assign phase    = phase_q;
  assign commit   = (phase_q == LAST_PH) && !stall;
  assign capture  = (phase_q == EX_PH) && !stall;

  // Redirect decision for the instruction currently presented on the inputs.
  always_comb begin
    live_vld = 1'b0;
    live_tgt = pc + imm;
    case (jmp)
      JMP_BR:   live_vld = br_cond;
      JMP_JAL:  live_vld = 1'b1;
      JMP_JALR: begin
        live_vld = 1'b1;
        live_tgt = (rs1_val + imm) & ~32'd1;
      end
      default:  live_vld = 1'b0;
    endcase
  end

  assign eff_vld = EX_IS_LAST ? live_vld : redir_vld_q;
  assign eff_tgt = EX_IS_LAST ? live_tgt : redir_tgt_q;

  always_comb begin
    phase_d     = phase_q;
    redir_vld_d = redir_vld_q;
    redir_tgt_d = redir_tgt_q;

    if (!stall) begin
      phase_d = (phase_q == LAST_PH) ? 3'd0 : phase_q + 3'd1;
    end

    // Commit clears the redirect; it wins over capture when both land on one edge.
    if (commit) begin
      redir_vld_d = 1'b0;
    end else if (capture) begin
      redir_vld_d = live_vld;
      if (live_vld) begin
        redir_tgt_d = live_tgt;
      end
    end
  end

  always_comb begin
    npc      = pc;
    misalign = 1'b0;
    if (commit) begin
      if (eff_vld) begin
        if (TRAP_EN && eff_tgt[1]) begin
          npc      = TRAP_VEC;
          misalign = 1'b1;
        end else begin
          npc = eff_tgt;
        end
      end else begin
        npc = pc_plus4;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 3'd0;
      redir_vld_q <= 1'b0;
      redir_tgt_q <= 32'd0;
    end else begin
      phase_q     <= phase_d;
      redir_vld_q <= redir_vld_d;
      redir_tgt_q <= redir_tgt_d;
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit: directed vector table, stall/reset sequences, random run vs model.
module tb_npc_unit;

  localparam int          C    = 5;
  localparam logic [31:0] TRAP = 32'h0000_0100;
`ifdef NPC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0, imm = '0, rs1_val = '0;
  logic [1:0]  jmp_type = '0;
  logic        br_cond = 1'b0, stall = 1'b0;
  logic [31:0] npc, pc4;
  logic [2:0]  phase;
  logic        commit, misalign;

  int n_total = 0;
  int n_pass  = 0;

  npc_unit #(.CYCLES(C), .TRAP_VEC(TRAP)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .jmp_type(jmp_type), .br_cond(br_cond),
    .imm(imm), .rs1_val(rs1_val), .stall(stall), .npc(npc), .pc4(pc4),
    .phase(phase), .commit(commit), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [1:0]  jt;
    logic        br;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_npc;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] p, input logic [1:0] jt, input logic br,
                       input logic [31:0] im, input logic [31:0] r1, input logic st);
    pc = p; jmp_type = jt; br_cond = br; imm = im; rs1_val = r1; stall = st;
  endtask

  // Reset released just after a rising edge so the next falling edge sees phase 0.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One whole unstalled instruction with constant inputs, checked every phase.
  task automatic run_vec(input vec_t v);
    for (int k = 0; k < C; k++) begin
      @(negedge clk);
      drive(v.pc, v.jt, v.br, v.imm, v.rs1, 1'b0);
      #1;
      check({v.name, " phase"}, 32'(phase), 32'(k));
      check({v.name, " pc4"}, pc4, v.pc + 32'd4);
      if (k == C - 1) begin
        check({v.name, " commit"}, 32'(commit), 32'd1);
        check({v.name, " npc@commit"}, npc, v.exp_npc);
        check({v.name, " misalign"}, 32'(misalign), 32'(v.exp_mis));
      end else begin
        check({v.name, " commit"}, 32'(commit), 32'd0);
        check({v.name, " npc hold"}, npc, v.pc);
      end
    end
  endtask

  // Reference: target of a control transfer from the instruction-set rules.
  function automatic logic [32:0] redirect_of(input logic [1:0] jt, input logic br,
      input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1);
    case (jt)
      2'b01:   return br ? {1'b1, p + im} : {1'b0, 32'd0};
      2'b10:   return {1'b1, p + im};
      2'b11:   return {1'b1, (r1 + im) & 32'hFFFF_FFFE};
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  initial begin
    tbl[0] = '{"seq",       32'h10,        2'b00, 1'b0, 32'h0,          32'h0,    32'h14,        1'b0};
    tbl[1] = '{"br_taken",  32'h40,        2'b01, 1'b1, 32'hFFFF_FFF0,  32'h0,    32'h30,        1'b0};
    tbl[2] = '{"br_not",    32'h40,        2'b01, 1'b0, 32'hFFFF_FFF0,  32'h0,    32'h44,        1'b0};
    tbl[3] = '{"jalr",      32'h80,        2'b11, 1'b0, 32'h4,          32'h1001, 32'h1004,      1'b0};
    tbl[4] = '{"seq_wrap",  32'hFFFF_FFFC, 2'b00, 1'b0, 32'h0,          32'h0,    32'h0,         1'b0};
    tbl[5] = '{"jal_wrap",  32'hFFFF_FFF0, 2'b10, 1'b0, 32'h20,         32'h0,    32'h10,        1'b0};
    tbl[6] = '{"seq_brc1",  32'h100,       2'b00, 1'b1, 32'h40,         32'h0,    32'h104,       1'b0};
    tbl[7] = '{"jalr_neg",  32'h200,       2'b11, 1'b0, 32'hFFFF_FFFC,  32'h2001, 32'h1FFC,      1'b0};
    tbl[8] = '{"jal_fwd",   32'h400,       2'b10, 1'b1, 32'h1000,       32'h0,    32'h1400,      1'b0};
    tbl[9] = '{"jal_misal", 32'h0,         2'b10, 1'b0, 32'h6,          32'h0,    TRAP_EN ? TRAP : 32'h6, TRAP_EN};

    // Reset state.
    drive(32'h10, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0);
    #3;
    check("rst phase", 32'(phase), 32'd0);
    check("rst commit", 32'(commit), 32'd0);
    check("rst npc", npc, 32'h10);
    check("rst misalign", 32'(misalign), 32'd0);
    do_reset();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Stall three cycles in EX, then two cycles in the last phase.
    begin
      int          exp_ph[10]  = '{0, 1, 2, 2, 2, 2, 3, 4, 4, 4};
      bit          st_pat[10]  = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        drive(32'h300, 2'b10, 1'b0, 32'h8, 32'h0, st_pat[k]);
        #1;
        check("stall phase", 32'(phase), 32'(exp_ph[k]));
        check("stall commit", 32'(commit), (k == 9) ? 32'd1 : 32'd0);
        check("stall npc", npc, (k == 9) ? 32'h308 : 32'h300);
      end
    end

    // Reset pulsed in phase 3 after a captured jal.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(32'h500, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
    end
    #1;
    check("pre-rst phase", 32'(phase), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst phase", 32'(phase), 32'd0);
    check("midrst redir_vld", 32'(dut.redir_vld_q), 32'd0);
    check("midrst commit", 32'(commit), 32'd0);
    check("midrst npc", npc, 32'h500);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_vec('{"post_rst", 32'h500, 2'b00, 1'b0, 32'h40, 32'h0, 32'h504, 1'b0});

    // Random run against the instruction-level model.
    do_reset();
    begin
      int          m_ph  = 0;
      bit          m_vld = 0;
      logic [31:0] m_tgt = '0;
      for (int n = 0; n < 400; n++) begin
        logic [32:0] r;
        logic        e_commit, e_mis;
        logic [31:0] e_npc;
        @(negedge clk);
        drive($urandom, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
              $urandom_range(0, 3) == 0);
        #1;
        r        = redirect_of(jmp_type, br_cond, pc, imm, rs1_val);
        e_commit = (m_ph == C - 1) && !stall;
        e_mis    = e_commit && m_vld && TRAP_EN && m_tgt[1];
        e_npc    = !e_commit ? pc : !m_vld ? pc + 32'd4 : e_mis ? TRAP : m_tgt;
        check("rnd phase", 32'(phase), 32'(m_ph));
        check("rnd commit", 32'(commit), 32'(e_commit));
        check("rnd npc", npc, e_npc);
        check("rnd pc4", pc4, pc + 32'd4);
        check("rnd misalign", 32'(misalign), 32'(e_mis));
        if (e_commit) m_vld = 0;
        else if (m_ph == 2 && !stall) begin
          m_vld = r[32];
          if (r[32]) m_tgt = r[31:0];
        end
        if (!stall) m_ph = (m_ph + 1) % C;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
